um_arith_issue: RTL and testbench

- Issue/writeback stage directly upstream of the 4-function ALU (add/mul/div/nand).
- Accepts one 32-bit UM instruction word at a time and decodes it.
- Owns the 8x32 general register file, drives ALU operands and op select, and captures the ALU result back into register A.
- Also executes the non-ALU register ops: conditional move and orthography.

---
 rtl/um_arith_issue.sv | 156 +++++++++++++++
 tb/tb_um_arith_issue.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/um_arith_issue.sv
// Issue/writeback stage for the UM 4-function ALU: decodes one instruction at a time, owns the
// 8x32 register file, drives ALU operands and captures the result into register A.
module um_arith_issue #(
  parameter int unsigned ALU_WAIT = 0
) (
  input  logic        clk,
  input  logic        r_n,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  output logic [1:0]  alu_s,
  input  logic [31:0] alu_out,
  output logic        done,
  output logic        unsup,
  output logic        fault,
  input  logic [2:0]  dbg_sel,
  output logic [31:0] dbg_data
);

  localparam int unsigned CntW = (ALU_WAIT > 0) ? $clog2(ALU_WAIT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StExec, StFault} state_e;

  state_e            state_q, state_d;
  logic [31:0]       instr_q;
  logic [31:0]       alu_x_q, alu_y_q;
  logic [1:0]        alu_s_q, alu_s_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              unsup_q, unsup_d;
  logic [31:0]       regs_q [8];

  logic              load;
  logic              we;
  logic [2:0]        wa;
  logic [31:0]       wd;

  logic [3:0]        op;
  logic [2:0]        ra, rb_in, rc_in;
  logic [3:0]        op_in;

  assign op    = instr_q[31:28];
  assign ra    = instr_q[8:6];
  assign op_in = in_instr[31:28];
  assign rb_in = in_instr[5:3];
  assign rc_in = in_instr[2:0];

  always_comb begin
    unique case (op_in)
      4'd4:    alu_s_d = 2'b01;
      4'd5:    alu_s_d = 2'b10;
      4'd6:    alu_s_d = 2'b11;
      default: alu_s_d = 2'b00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unsup_d = 1'b0;
    load    = 1'b0;
    we      = 1'b0;
    wa      = ra;
    wd      = '0;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = StExec;
        end
      end
      StExec: begin
        case (op)
          4'd0: begin
            // alu_x/alu_y hold reg[B]/reg[C] sampled at issue.
            we      = (alu_y_q != '0);
            wd      = alu_x_q;
            done_d  = 1'b1;
            state_d = StIdle;
          end
          4'd13: begin
            we      = 1'b1;
            wa      = instr_q[27:25];
            wd      = {7'b0, instr_q[24:0]};
            done_d  = 1'b1;
            state_d = StIdle;
          end
          4'd3, 4'd4, 4'd5, 4'd6: begin
            if (op == 4'd5 && alu_y_q == '0) begin
              state_d = StFault;
            end else if (cnt_q == CntW'(ALU_WAIT)) begin
              we      = 1'b1;
              wd      = alu_out;
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            unsup_d = 1'b1;
            state_d = StIdle;
          end
        endcase
      end
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      state_q <= StIdle;
      instr_q <= '0;
      alu_x_q <= '0;
      alu_y_q <= '0;
      alu_s_q <= 2'b00;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      unsup_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      unsup_q <= unsup_d;
      if (load) begin
        instr_q <= in_instr;
        alu_x_q <= regs_q[rb_in];
        alu_y_q <= regs_q[rc_in];
        alu_s_q <= alu_s_d;
      end
    end
  end

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[wa] <= wd;
    end
  end

  assign in_ready = (state_q == StIdle);
  assign fault    = (state_q == StFault);
  assign done     = done_q;
  assign unsup    = unsup_q;
  assign alu_x    = alu_x_q;
  assign alu_y    = alu_y_q;
  assign alu_s    = alu_s_q;
  assign dbg_data = regs_q[dbg_sel];

endmodule

// File: tb/tb_um_arith_issue.sv
// Bench for um_arith_issue: two instances (ALU_WAIT 0 and 3) behind a shared, selectable driver,
// with a register model and an expected-retire queue.
module tb_um_arith_issue;

  logic        clk = 1'b0;
  logic        r_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  dbg_sel;
  logic        sel;

  logic        in_ready0, done0, unsup0, fault0, in_ready1, done1, unsup1, fault1;
  logic [31:0] alu_x0, alu_y0, alu_out0, dbg_data0, alu_x1, alu_y1, alu_out1, dbg_data1;
  logic [1:0]  alu_s0, alu_s1;

  always #10 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [1:0] s, input logic [31:0] x,
                                        input logic [31:0] y);
    case (s)
      2'b00:   return x + y;
      2'b01:   return x * y;
      2'b10:   return (y == 0) ? 32'd0 : x / y;
      default: return ~(x & y);
    endcase
  endfunction

  assign alu_out0 = alu_f(alu_s0, alu_x0, alu_y0);
  assign alu_out1 = alu_f(alu_s1, alu_x1, alu_y1);

  um_arith_issue #(.ALU_WAIT(0)) u_dut0 (
    .clk(clk), .r_n(r_n), .in_valid(in_valid && !sel), .in_instr(in_instr),
    .in_ready(in_ready0), .alu_x(alu_x0), .alu_y(alu_y0), .alu_s(alu_s0), .alu_out(alu_out0),
    .done(done0), .unsup(unsup0), .fault(fault0), .dbg_sel(dbg_sel), .dbg_data(dbg_data0)
  );

  um_arith_issue #(.ALU_WAIT(3)) u_dut1 (
    .clk(clk), .r_n(r_n), .in_valid(in_valid && sel), .in_instr(in_instr),
    .in_ready(in_ready1), .alu_x(alu_x1), .alu_y(alu_y1), .alu_s(alu_s1), .alu_out(alu_out1),
    .done(done1), .unsup(unsup1), .fault(fault1), .dbg_sel(dbg_sel), .dbg_data(dbg_data1)
  );

  logic        ready_m, done_m, unsup_m, fault_m;
  logic [31:0] x_m, y_m, dbg_m;
  logic [1:0]  s_m;
  assign ready_m = sel ? in_ready1 : in_ready0;
  assign done_m  = sel ? done1 : done0;
  assign unsup_m = sel ? unsup1 : unsup0;
  assign fault_m = sel ? fault1 : fault0;
  assign x_m     = sel ? alu_x1 : alu_x0;
  assign y_m     = sel ? alu_y1 : alu_y0;
  assign s_m     = sel ? alu_s1 : alu_s0;
  assign dbg_m   = sel ? dbg_data1 : dbg_data0;

  typedef struct {
    int kind;  // 1 done, 2 unsup, 3 fault
    int lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m [8];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_regs();
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      check_val($sformatf("r%0d", i), dbg_m, m[i]);
    end
  endtask

  function automatic logic [31:0] ortho(input logic [2:0] a, input logic [24:0] imm);
    return {4'd13, a, imm};
  endfunction

  function automatic logic [31:0] rr(input logic [3:0] op, input logic [2:0] a,
                                     input logic [2:0] b, input logic [2:0] c);
    return {op, 19'b0, a, b, c};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m[i] = '0;
  endtask

  task automatic issue(input logic [31:0] instr);
    logic [3:0]  op;
    logic [2:0]  a, b, c;
    logic [1:0]  ex_s;
    logic [31:0] nv;
    logic        wr;
    exp_t        e;
    int          k, obs, w;
    w  = sel ? 3 : 0;
    op = instr[31:28];
    a  = instr[8:6];
    b  = instr[5:3];
    c  = instr[2:0];
    wr = 1'b0;
    nv = '0;
    ex_s = 2'b00;
    e.kind = 1;
    e.lat  = 2;
    case (op)
      4'd0: begin
        wr = (m[c] != 0);
        nv = m[b];
      end
      4'd13: begin
        a  = instr[27:25];
        nv = {7'b0, instr[24:0]};
        wr = 1'b1;
      end
      4'd3: begin ex_s = 2'b00; nv = m[b] + m[c]; wr = 1'b1; e.lat = 2 + w; end
      4'd4: begin ex_s = 2'b01; nv = m[b] * m[c]; wr = 1'b1; e.lat = 2 + w; end
      4'd6: begin ex_s = 2'b11; nv = ~(m[b] & m[c]); wr = 1'b1; e.lat = 2 + w; end
      4'd5: begin
        ex_s = 2'b10;
        if (m[c] == 0) begin
          e.kind = 3;
        end else begin
          nv = m[b] / m[c];
          wr = 1'b1;
          e.lat = 2 + w;
        end
      end
      default: e.kind = 2;
    endcase
    exp_q.push_back(e);

    @(negedge clk);
    check_val("ready_pre", 32'(ready_m), 32'd1);
    in_valid = 1'b1;
    in_instr = instr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_instr = $urandom;
    if (op >= 4'd3 && op <= 4'd6) begin
      check_val("alu_x", x_m, m[b]);
      check_val("alu_y", y_m, m[c]);
      check_val("alu_s", 32'(s_m), 32'(ex_s));
    end
    if (wr && e.kind == 1) m[a] = nv;

    k = 0;
    obs = 0;
    while (k < 20 && obs == 0) begin
      @(negedge clk);
      k++;
      if (done_m) obs = 1;
      else if (unsup_m) obs = 2;
      else if (fault_m) obs = 3;
    end
    e = exp_q.pop_front();
    check_val("retire_kind", 32'(obs), 32'(e.kind));
    check_val("latency", 32'(k), 32'(e.lat));
    check_val("done_unsup_excl", 32'(done_m & unsup_m), 32'd0);
    if (obs == 1 || obs == 2) begin
      check_val("ready_at_retire", 32'(ready_m), 32'd1);
      @(negedge clk);
      check_val("pulse_len", 32'(done_m | unsup_m), 32'd0);
    end
    check_regs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    r_n = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    dbg_sel = '0;
    sel = 1'b0;
    model_reset();
    #25;
    check_val("rst_ready", 32'(in_ready0), 32'd1);
    check_val("rst_alu_x", alu_x0, 32'd0);
    check_val("rst_alu_y", alu_y0, 32'd0);
    check_val("rst_alu_s", 32'(alu_s0), 32'd0);
    check_val("rst_flags", {29'b0, done0, unsup0, fault0}, 32'd0);
    check_regs();
    @(negedge clk);
    r_n = 1'b1;

    issue(ortho(3'd1, 25'd7));
    issue(ortho(3'd2, 25'd5));
    issue(rr(4'd3, 3'd3, 3'd1, 3'd2));
    dbg_sel = 3'd3; #1;
    check_val("add_r3", dbg_m, 32'd12);

    issue(ortho(3'd1, 25'h1FFFFFF));
    issue(rr(4'd4, 3'd4, 3'd1, 3'd1));
    dbg_sel = 3'd4; #1;
    check_val("mul_wrap", dbg_m, 32'hFC000001);
    issue(rr(4'd6, 3'd5, 3'd0, 3'd0));
    dbg_sel = 3'd5; #1;
    check_val("nand_r5", dbg_m, 32'hFFFFFFFF);

    issue(ortho(3'd1, 25'd100));
    issue(ortho(3'd2, 25'd7));
    issue(rr(4'd5, 3'd3, 3'd1, 3'd2));
    dbg_sel = 3'd3; #1;
    check_val("div_r3", dbg_m, 32'd14);

    issue(ortho(3'd1, 25'd9));
    issue(ortho(3'd2, 25'd0));
    issue(rr(4'd0, 3'd3, 3'd1, 3'd2));
    issue(ortho(3'd2, 25'd1));
    issue(rr(4'd0, 3'd3, 3'd1, 3'd2));
    dbg_sel = 3'd3; #1;
    check_val("cmov_r3", dbg_m, 32'd9);
    issue(rr(4'd3, 3'd2, 3'd2, 3'd2));

    issue(rr(4'd7, 3'd1, 3'd2, 3'd3));
    issue(rr(4'd15, 3'd1, 3'd2, 3'd3));

    // Divide by zero: stage must lock up and ignore further traffic.
    issue(rr(4'd5, 3'd3, 3'd1, 3'd0));
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = ortho(3'd3, 25'd77);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("fault_ready", 32'(in_ready0), 32'd0);
      check_val("fault_sticky", 32'(fault0), 32'd1);
      check_val("fault_no_done", 32'(done0 | unsup0), 32'd0);
    end
    in_valid = 1'b0;
    check_regs();

    r_n = 1'b0;
    model_reset();
    #1;
    check_val("fault_cleared", 32'(fault0), 32'd0);
    @(negedge clk);
    r_n = 1'b1;
    sel = 1'b1;

    issue(ortho(3'd1, 25'd2));
    issue(ortho(3'd2, 25'd3));
    issue(rr(4'd3, 3'd3, 3'd1, 3'd2));
    issue(rr(4'd5, 3'd4, 3'd2, 3'd1));

    // Abort an ALU op mid-wait.
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = rr(4'd3, 3'd5, 3'd1, 3'd2);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    r_n = 1'b0;
    model_reset();
    #1;
    check_val("abort_ready", 32'(in_ready1), 32'd1);
    check_val("abort_alu_x", alu_x1, 32'd0);
    @(negedge clk);
    r_n = 1'b1;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done1 || unsup1) k++;
    end
    check_val("abort_no_done", 32'(k), 32'd0);
    check_regs();

    issue(ortho(3'd6, 25'h55));
    issue(rr(4'd3, 3'd7, 3'd6, 3'd6));
    dbg_sel = 3'd7; #1;
    check_val("post_abort_add", dbg_m, 32'hAA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
